// File: rtl/bldc_hall_sequencer_pkg.sv
// Shared types, constants and the hall-code to sector lookup for the BLDC hall sequencer.
package bldc_hall_sequencer_pkg;

   localparam int unsigned HALL_W   = 3;
   localparam int unsigned SECTOR_W = 3;

   localparam logic [SECTOR_W-1:0] SECTOR_INVALID = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALIGN = 2'd1,
      ST_RUN   = 2'd2,
      ST_FAULT = 2'd3
   } state_e;

   // Forward rotation visits sectors 0..5; 000 and 111 are never produced by a healthy sensor.
   function automatic logic [SECTOR_W-1:0] hall_to_sector(input logic [HALL_W-1:0] code);
      logic [SECTOR_W-1:0] sec;
      case (code)
         3'b101:  sec = 3'd0;
         3'b100:  sec = 3'd1;
         3'b110:  sec = 3'd2;
         3'b010:  sec = 3'd3;
         3'b011:  sec = 3'd4;
         3'b001:  sec = 3'd5;
         default: sec = SECTOR_INVALID;
      endcase
      return sec;
   endfunction

endpackage

// File: rtl/bldc_hall_sequencer_hall_debounce.sv
// Two-flop synchroniser plus stability counter for the three hall inputs.
// A code is accepted once the synchronised value has been seen DEBOUNCE_CYCLES
// consecutive times, giving a raw-to-output latency of DEBOUNCE_CYCLES+2 clocks.
module bldc_hall_sequencer_hall_debounce
   import bldc_hall_sequencer_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [HALL_W-1:0]   hall_raw,
   output logic [HALL_W-1:0]   hall_code,
   output logic [SECTOR_W-1:0] sector
);

   localparam int unsigned          CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0]     CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]     ACCEPT_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [HALL_W-1:0] sync1_q;
   logic [HALL_W-1:0] sync2_q;
   logic [HALL_W-1:0] cand_q;
   logic [CNT_W-1:0]  cnt_q;

   // Synchronise, track the candidate code and commit it after enough stable samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         cand_q    <= '0;
         cnt_q     <= '0;
         hall_code <= '0;
         sector    <= SECTOR_INVALID;
      end else begin
         sync1_q <= hall_raw;
         sync2_q <= sync1_q;
         if (sync2_q != cand_q) begin
            cand_q <= sync2_q;
            cnt_q  <= CNT_W'(1);
            if (DEBOUNCE_CYCLES == 1) begin
               hall_code <= sync2_q;
               sector    <= hall_to_sector(sync2_q);
            end
         end else begin
            if (cnt_q != CNT_MAX) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
            if (cnt_q == ACCEPT_CNT) begin
               hall_code <= cand_q;
               sector    <= hall_to_sector(cand_q);
            end
         end
      end
   end

endmodule

// File: rtl/bldc_hall_sequencer.sv
// Hall front-end for BLDC commutation: sequence checking, period/stall measurement,
// fault latching and the commutation enable.
module bldc_hall_sequencer
   import bldc_hall_sequencer_pkg::*;
#(
   parameter int unsigned REG_SIZE        = 16,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned STALL_CYCLES    = 50000,
   parameter int unsigned SKIP_LIMIT      = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                fault_clr,
   input  logic                hall_1,
   input  logic                hall_2,
   input  logic                hall_3,
   output logic [HALL_W-1:0]   hall_code,
   output logic [SECTOR_W-1:0] sector,
   output logic                direction,
   output logic [REG_SIZE-1:0] period_out,
   output logic                period_valid,
   output logic                commutate_en,
   output logic                hall_error,
   output logic                seq_error,
   output logic                stall,
   output logic [1:0]          state
);

   localparam int unsigned          SKIP_W    = $clog2(SKIP_LIMIT + 1);
   localparam logic [REG_SIZE-1:0]  CNT_SAT   = '1;
   localparam logic [REG_SIZE-1:0]  STALL_VAL = REG_SIZE'(STALL_CYCLES);
   localparam logic [SKIP_W-1:0]    SKIP_MAX  = SKIP_W'(SKIP_LIMIT);

   state_e              state_q;
   state_e              state_d;
   logic [HALL_W-1:0]   code_prev_q;
   logic [REG_SIZE-1:0] cnt_q;
   logic [REG_SIZE-1:0] cnt_d;
   logic [REG_SIZE-1:0] cnt_inc_c;
   logic [SKIP_W-1:0]   skip_q;
   logic [SKIP_W-1:0]   skip_d;
   logic                direction_d;
   logic [REG_SIZE-1:0] period_d;
   logic                period_valid_d;
   logic                commutate_en_d;
   logic                hall_error_d;
   logic                seq_error_d;
   logic                stall_d;
   logic                fault_c;
   logic [SECTOR_W-1:0] sector_prev_c;
   logic                new_valid_c;
   logic                old_valid_c;
   logic                hall_chg_c;
   logic [3:0]          step_c;

   bldc_hall_sequencer_hall_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .hall_raw  ({hall_1, hall_2, hall_3}),
      .hall_code (hall_code),
      .sector    (sector)
   );

   // Classify the latest accepted change as a step of (new - old) mod 6 sectors.
   always_comb begin
      sector_prev_c = hall_to_sector(code_prev_q);
      new_valid_c   = (sector != SECTOR_INVALID);
      old_valid_c   = (sector_prev_c != SECTOR_INVALID);
      hall_chg_c    = (hall_code != code_prev_q);
      step_c        = 4'(sector) + 4'd6 - 4'(sector_prev_c);
      if (step_c >= 4'd6) begin
         step_c = step_c - 4'd6;
      end
      cnt_inc_c = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + REG_SIZE'(1);
   end

   // Next-state and next-register logic for the FSM, counters and fault flags.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      skip_d         = skip_q;
      direction_d    = direction;
      period_d       = period_out;
      period_valid_d = 1'b0;
      hall_error_d   = hall_error;
      seq_error_d    = seq_error;
      stall_d        = stall;
      fault_c        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (enable) begin
               state_d = ST_ALIGN;
            end
         end
         ST_ALIGN: begin
            cnt_d = '0;
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (new_valid_c) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_inc_c;
            if (hall_chg_c && new_valid_c && old_valid_c) begin
               cnt_d = '0;
               if (step_c == 4'd1 || step_c == 4'd5) begin
                  direction_d    = (step_c == 4'd1);
                  period_d       = cnt_inc_c;
                  period_valid_d = 1'b1;
                  skip_d         = '0;
               end else if (skip_q != SKIP_MAX) begin
                  skip_d = skip_q + SKIP_W'(1);
               end
            end
            if (!new_valid_c) begin
               hall_error_d = 1'b1;
               fault_c      = 1'b1;
            end
            if (skip_q == SKIP_MAX) begin
               seq_error_d = 1'b1;
               fault_c     = 1'b1;
            end
            if (cnt_q == STALL_VAL) begin
               stall_d = 1'b1;
               fault_c = 1'b1;
            end
            if (fault_c) begin
               state_d = ST_FAULT;
            end else if (!enable) begin
               state_d = ST_IDLE;
            end
         end
         ST_FAULT: begin
            cnt_d = '0;
            if (fault_clr) begin
               state_d      = ST_IDLE;
               hall_error_d = 1'b0;
               seq_error_d  = 1'b0;
               stall_d      = 1'b0;
               skip_d       = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      commutate_en_d = (state_d == ST_RUN);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         code_prev_q  <= '0;
         cnt_q        <= '0;
         skip_q       <= '0;
         direction    <= 1'b0;
         period_out   <= '0;
         period_valid <= 1'b0;
         commutate_en <= 1'b0;
         hall_error   <= 1'b0;
         seq_error    <= 1'b0;
         stall        <= 1'b0;
      end else begin
         state_q      <= state_d;
         code_prev_q  <= hall_code;
         cnt_q        <= cnt_d;
         skip_q       <= skip_d;
         direction    <= direction_d;
         period_out   <= period_d;
         period_valid <= period_valid_d;
         commutate_en <= commutate_en_d;
         hall_error   <= hall_error_d;
         seq_error    <= seq_error_d;
         stall        <= stall_d;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_bldc_hall_sequencer.sv
// Randomised scoreboard bench for bldc_hall_sequencer.
module tb_bldc_hall_sequencer;

   localparam int unsigned REG_SIZE = 16;
   localparam int unsigned DEB      = 4;
   localparam int unsigned STALL    = 200;
   localparam int unsigned SKIPS    = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic                enable;
   logic                fault_clr;
   logic                hall_1;
   logic                hall_2;
   logic                hall_3;
   logic [2:0]          hall_code;
   logic [2:0]          sector;
   logic                direction;
   logic [REG_SIZE-1:0] period_out;
   logic                period_valid;
   logic                commutate_en;
   logic                hall_error;
   logic                seq_error;
   logic                stall;
   logic [1:0]          state;

   bldc_hall_sequencer #(
      .REG_SIZE        (REG_SIZE),
      .DEBOUNCE_CYCLES (DEB),
      .STALL_CYCLES    (STALL),
      .SKIP_LIMIT      (SKIPS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .fault_clr    (fault_clr),
      .hall_1       (hall_1),
      .hall_2       (hall_2),
      .hall_3       (hall_3),
      .hall_code    (hall_code),
      .sector       (sector),
      .direction    (direction),
      .period_out   (period_out),
      .period_valid (period_valid),
      .commutate_en (commutate_en),
      .hall_error   (hall_error),
      .seq_error    (seq_error),
      .stall        (stall),
      .state        (state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic dir;
      int   period;
      bit   chk_period;
   } exp_t;

   exp_t       sb_q[$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;

   // Forward rotation order of hall codes; position in this list is the sector.
   logic [2:0] rot [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

   // Reference model state.
   logic [2:0] m_code;
   bit         m_run;
   bit         m_first;
   int         last_t;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int msec(input logic [2:0] c);
      for (int i = 0; i < 6; i++) begin
         if (rot[i] == c) return i;
      end
      return 7;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive a new raw code, predict the sequencer's reaction, then hold it.
   task automatic hall_step(input logic [2:0] code, input int hold);
      int   so;
      int   sn;
      int   d;
      exp_t e;
      so = msec(m_code);
      sn = msec(code);
      if (m_run && so < 6 && sn < 6 && code != m_code) begin
         d = (sn - so + 6) % 6;
         if (d == 1 || d == 5) begin
            e.dir        = (d == 1);
            e.period     = cyc - last_t;
            e.chk_period = !m_first;
            sb_q.push_back(e);
         end
         last_t  = cyc;
         m_first = 1'b0;
      end
      if (sn >= 6) m_run = 1'b0;
      m_code = code;
      {hall_1, hall_2, hall_3} = code;
      tick(hold);
   endtask

   // mode 0 forward, 1 reverse, 2 random direction.
   task automatic walk(input int n, input int mode, input int lo, input int hi);
      int s;
      int nx;
      for (int k = 0; k < n; k++) begin
         s = msec(m_code);
         if (mode == 0 || (mode == 2 && $urandom_range(1, 0) == 1)) nx = (s + 1) % 6;
         else nx = (s + 5) % 6;
         hall_step(rot[nx], int'($urandom_range(hi, lo)));
      end
   endtask

   task automatic wait_state(input int st, input int budget, input string name);
      int i;
      i = 0;
      while (int'(state) != st && i < budget) begin
         tick(1);
         i++;
      end
      chk(name, int'(state), st);
   endtask

   task automatic pulse_clr();
      fault_clr = 1'b1;
      tick(1);
      fault_clr = 1'b0;
   endtask

   task automatic check_flags(input string tag, input int he, input int se, input int st);
      chk({tag, "_hall_error"}, int'(hall_error), he);
      chk({tag, "_seq_error"}, int'(seq_error), se);
      chk({tag, "_stall"}, int'(stall), st);
   endtask

   // Monitor: every period_valid pulse must match the oldest predicted transition.
   always @(negedge clk) begin
      exp_t e;
      if (period_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_period_valid", 1, 0);
         end else begin
            e = sb_q.pop_front();
            chk("sb_direction", int'(direction), int'(e.dir));
            if (e.chk_period) chk("sb_period", int'(period_out), e.period);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int i;
      rst       = 1'b1;
      enable    = 1'b1;
      fault_clr = 1'b0;
      {hall_1, hall_2, hall_3} = 3'b101;
      m_run   = 1'b0;
      m_first = 1'b1;
      m_code  = 3'b101;
      last_t  = 0;
      tick(3);

      // Reset values.
      chk("rst_state", int'(state), 0);
      chk("rst_sector", int'(sector), 7);
      chk("rst_hall_code", int'(hall_code), 0);
      chk("rst_commutate_en", int'(commutate_en), 0);
      chk("rst_period_out", int'(period_out), 0);
      check_flags("rst", 0, 0, 0);

      // Start-up: IDLE -> ALIGN -> RUN within 8 clocks.
      rst = 1'b0;
      i = 0;
      while (commutate_en !== 1'b1 && i < 8) begin
         tick(1);
         i++;
      end
      chk("startup_commutate_en", int'(commutate_en), 1);
      chk("startup_state", int'(state), 2);
      chk("startup_sector", int'(sector), 0);
      m_run   = 1'b1;
      m_first = 1'b1;

      // Forward rotation, fixed then random step lengths.
      walk(5, 0, 50, 50);
      chk("fwd_period_out", int'(period_out), 50);
      walk(6, 0, 30, 120);
      chk("fwd_direction", int'(direction), 1);
      chk("fwd_state", int'(state), 2);
      chk("fwd_hall_code", int'(hall_code), int'(m_code));
      check_flags("fwd", 0, 0, 0);

      // Reverse rotation.
      walk(2, 1, 40, 40);
      chk("rev_direction", int'(direction), 0);
      chk("rev_period_out", int'(period_out), 40);
      chk("rev_sector", int'(sector), msec(m_code));

      // Random direction walk.
      walk(10, 2, 30, 120);
      chk("walk_state", int'(state), 2);
      check_flags("walk", 0, 0, 0);

      // Short glitch to 111 must be filtered out.
      {hall_1, hall_2, hall_3} = 3'b111;
      tick(int'($urandom_range(DEB - 1, 1)));
      {hall_1, hall_2, hall_3} = m_code;
      tick(20);
      chk("glitch_hall_code", int'(hall_code), int'(m_code));
      chk("glitch_hall_error", int'(hall_error), 0);
      chk("glitch_state", int'(state), 2);

      // Sustained invalid code faults.
      hall_step(3'b111, 12);
      chk("invalid_state", int'(state), 3);
      chk("invalid_commutate_en", int'(commutate_en), 0);
      check_flags("invalid", 1, 0, 0);

      // Clear, re-align, then stall.
      pulse_clr();
      chk("clr1_state", int'(state), 0);
      check_flags("clr1", 0, 0, 0);
      tick(1);
      chk("clr1_align", int'(state), 1);
      {hall_1, hall_2, hall_3} = 3'b101;
      m_code = 3'b101;
      wait_state(2, 12, "realign1_run");
      m_run   = 1'b1;
      m_first = 1'b1;
      hall_step(3'b100, 150);
      chk("prestall_stall", int'(stall), 0);
      chk("prestall_state", int'(state), 2);
      tick(70);
      chk("stall_state", int'(state), 3);
      chk("stall_commutate_en", int'(commutate_en), 0);
      check_flags("stall", 0, 0, 1);
      m_run = 1'b0;

      pulse_clr();
      chk("clr2_state", int'(state), 0);
      check_flags("clr2", 0, 0, 0);
      tick(1);
      chk("clr2_align", int'(state), 1);
      wait_state(2, 12, "realign2_run");
      m_run   = 1'b1;
      m_first = 1'b1;

      // Three consecutive skips fault.
      hall_step(3'b101, 40);
      hall_step(3'b110, 40);
      hall_step(3'b011, 40);
      chk("skip2_state", int'(state), 2);
      hall_step(3'b101, 12);
      chk("skip_state", int'(state), 3);
      chk("skip_commutate_en", int'(commutate_en), 0);
      check_flags("skip", 0, 1, 0);
      m_run = 1'b0;

      pulse_clr();
      check_flags("clr3", 0, 0, 0);
      wait_state(2, 12, "realign3_run");
      m_run   = 1'b1;
      m_first = 1'b1;
      hall_step(3'b100, 60);
      hall_step(3'b110, 60);
      chk("post_clr_direction", int'(direction), 1);

      // Reset mid-run.
      rst = 1'b1;
      tick(1);
      m_run = 1'b0;
      chk("midrst_state", int'(state), 0);
      chk("midrst_commutate_en", int'(commutate_en), 0);
      chk("midrst_sector", int'(sector), 7);
      chk("midrst_hall_code", int'(hall_code), 0);
      chk("midrst_period_out", int'(period_out), 0);
      chk("midrst_period_valid", int'(period_valid), 0);
      chk("midrst_direction", int'(direction), 0);
      check_flags("midrst", 0, 0, 0);
      rst = 1'b0;
      tick(2);

      chk("sb_leftover", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
